// File: rtl/fact_mmio.sv
`default_nettype none
// ============================================================================
// Module   : fact_mmio
// Brief    : Memory-mapped iterative factorial accelerator. One multiply per
//            cycle with overflow abort, busy flag, W1C status and an optional
//            completion interrupt enabled by the FACT_MMIO_IRQ_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module fact_mmio #(
  parameter int WIDTH = 32,
  parameter int NBITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  a,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq
);

  localparam int PW = WIDTH + NBITS;
  localparam logic [NBITS-1:0] C_CNT_ONE = NBITS'(1);
  localparam logic [WIDTH-1:0] C_ACC_ONE = WIDTH'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [NBITS-1:0] n_q, n_d;
  logic [NBITS-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             ie_q, ie_d;
  logic             irq_q, irq_d;

  logic             busy_w;
  logic             wr_n_w, wr_ctrl_w, wr_stat_w;
  logic [PW-1:0]    prod_w;
  logic             ovf_w;
  logic [31:0]      res_hi_w;
  logic             unused_w;

  assign busy_w    = (state_q == S_RUN);
  assign wr_n_w    = we && (a == 3'd0);
  assign wr_ctrl_w = we && (a == 3'd1);
  assign wr_stat_w = we && (a == 3'd2);

  // Full-width product so any bit above WIDTH signals overflow.
  assign prod_w = PW'(acc_q) * PW'(cnt_q);
  assign ovf_w  = |prod_w[PW-1:WIDTH];

  // Upper bits of wd beyond the implemented fields are intentionally ignored.
  assign unused_w = ^wd;

  generate
    if (WIDTH > 32) begin : g_res_hi
      assign res_hi_w = 32'(res_q[WIDTH-1:32]);
    end else begin : g_res_hi_zero
      assign res_hi_w = 32'd0;
    end
  endgenerate

  // Next-state: register writes first, then FSM so completion sets win over clears.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    res_d   = res_q;
    done_d  = done_q;
    err_d   = err_q;
    ie_d    = ie_q;
    irq_d   = 1'b0;

    if (wr_n_w) begin
      n_d = wd[NBITS-1:0];
    end
`ifdef FACT_MMIO_IRQ_EN
    if (wr_ctrl_w) begin
      ie_d = wd[1];
    end
    irq_d = done_q & ie_q;
`endif
    if (wr_stat_w) begin
      if (wd[0]) done_d = 1'b0;
      if (wd[1]) err_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (wr_ctrl_w && wd[0]) begin
          acc_d   = C_ACC_ONE;
          cnt_d   = n_q;
          done_d  = 1'b0;
          err_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q <= C_CNT_ONE) begin
          res_d   = acc_q;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (ovf_w) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          acc_d = prod_w[WIDTH-1:0];
          cnt_d = cnt_q - C_CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ie_q    <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ie_q    <= ie_d;
      irq_q   <= irq_d;
    end
  end

  // Side-effect-free combinational read mux.
  always_comb begin
    rd = 32'd0;
    case (a)
      3'd0:    rd = 32'(n_q);
      3'd1:    rd = {30'd0, ie_q, busy_w};
      3'd2:    rd = {29'd0, busy_w, err_q, done_q};
      3'd3:    rd = res_q[31:0];
      3'd4:    rd = res_hi_w;
      default: rd = 32'd0;
    endcase
  end

  assign irq = irq_q;

endmodule
`default_nettype wire
